// File: rtl/chunked_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, CHUNK bits per cycle,
// borrow rippled between cycles. Valid/ready on both operand and result sides.
module chunked_subtractor #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned LastW  = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // Valid bits of the (possibly narrower) top chunk.
  localparam logic [CHUNK-1:0] LastMask = {CHUNK{1'b1}} >> (CHUNK - LastW);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             accept;
  logic             last;
  logic [31:0]      off;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CHUNK-1:0] cmask, a_c, b_c;
  logic [CHUNK:0]   sub;
  logic [WIDTH-1:0] wmask, wdata, diff_next;

  // Handshake decode from registered state; held low while reset is asserted.
  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign diff      = diff_q;
  assign bout      = bout_q;

  // Chunk datapath: extract current chunk, subtract with borrow, merge into diff.
  always_comb begin
    last  = (idx_q == IdxW'(NCHUNK - 1));
    off   = 32'(idx_q) * 32'(CHUNK);
    a_sh  = a_q >> off;
    b_sh  = b_q >> off;
    cmask = last ? LastMask : {CHUNK{1'b1}};
    a_c   = a_sh[CHUNK-1:0] & cmask;
    b_c   = b_sh[CHUNK-1:0] & cmask;
    // Operands are zero-extended at their true width, so a negative result sets
    // every bit above it; bit CHUNK is the borrow for full and short chunks alike.
    sub   = {1'b0, a_c} - {1'b0, b_c} - {{CHUNK{1'b0}}, borrow_q};
    wmask = WIDTH'(cmask) << off;
    wdata = WIDTH'(sub[CHUNK-1:0] & cmask) << off;
    diff_next = (diff_q & ~wmask) | wdata;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand capture, chunk index, borrow chain and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      if (state_q == StIdle && accept) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bin;
        idx_q    <= '0;
      end else if (state_q == StCalc) begin
        diff_q   <= diff_next;
        borrow_q <= sub[CHUNK];
        if (last) bout_q <= sub[CHUNK];
        else      idx_q  <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor at WIDTH=65, CHUNK=16.
module tb_chunked_subtractor;

  localparam int unsigned W   = 65;
  localparam int          LAT = 6;  // accept-to-result cycles at defaults

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  chunked_subtractor #(.WIDTH(65), .CHUNK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: exact subtraction in one extra bit; the top bit is the borrow.
  task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                         output logic [W-1:0] rd, output logic rbo);
    logic [W:0] t;
    t   = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
    rd  = t[W-1:0];
    rbo = t[W];
  endtask

  function automatic logic [W-1:0] rand65();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Issue one operation and collect its result; reports latency and in_ready behaviour.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input int hold, output logic [W-1:0] rd, output logic rbo,
                        output int lat, output logic busy_ok, output logic ok);
    int n;
    ok = 1'b1;
    busy_ok = 1'b1;
    rd = '0; rbo = 1'b0; lat = 0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin ok = 1'b0; return; end
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = rand65(); b = rand65(); bin = $urandom_range(0, 1);
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    if (!out_valid) begin ok = 1'b0; return; end
    rd = diff; rbo = bout;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || diff !== rd || bout !== rbo) busy_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (!in_ready || out_valid) busy_ok = 1'b0;
  endtask

  initial begin
    vec_t         vecs[6];
    logic [W-1:0] rd, md;
    logic         rbo, mbo, busy_ok, ok;
    int           lat;
    logic [W-1:0] held_d;
    logic         held_b, bp_ok, stale;

    vecs[0] = '{65'd5, 65'd3, 1'b0, 65'd2, 1'b0};
    vecs[1] = '{65'd0, 65'd1, 1'b0, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2] = '{65'h1_0000_0000_0000_0000, 65'd0, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[3] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1,
                65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[4] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0, 65'd0, 1'b0};
    vecs[5] = '{65'h0_8000_0000_0000_0000, 65'h0_0000_0000_0001_0000, 1'b1,
                65'h0_7FFF_FFFF_FFFE_FFFF, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready), 128'(0));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_diff", 128'(diff), 128'(0));
    check("reset_bout", 128'(bout), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 128'(in_ready), 128'(1));

    // Directed table, issued back to back (next op offered right after handshake).
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, rd, rbo, lat, busy_ok, ok);
      check($sformatf("vec%0d_done", i), 128'(ok), 128'(1));
      check($sformatf("vec%0d_diff", i), 128'(rd), 128'(vecs[i].exp_diff));
      check($sformatf("vec%0d_bout", i), 128'(rbo), 128'(vecs[i].exp_bout));
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(LAT));
      check($sformatf("vec%0d_ready_seq", i), 128'(busy_ok), 128'(1));
    end

    // Backpressure: result held for 10 cycles while new operands wait.
    run_op_start(65'd100, 65'd7, 1'b0);
    held_d = diff; held_b = bout;
    check("bp_first_diff", 128'(held_d), 128'(93));
    a = 65'h1_2345_6789_ABCD_EF01; b = 65'h0_FEDC_BA98_7654_3210; bin = 1'b1; in_valid = 1'b1;
    bp_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || diff !== held_d || bout !== held_b) bp_ok = 1'b0;
    end
    check("bp_hold", 128'(bp_ok), 128'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept", 128'(in_ready), 128'(0));
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    ref_sub(65'h1_2345_6789_ABCD_EF01, 65'h0_FEDC_BA98_7654_3210, 1'b1, md, mbo);
    check("bp_second_latency", 128'(lat), 128'(LAT));
    check("bp_second_diff", 128'(diff), 128'(md));
    check("bp_second_bout", 128'(bout), 128'(mbo));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while processing chunk index 2.
    a = 65'h1_0000_0000_0000_0000; b = 65'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;   // accepted; idx 0 now
    in_valid = 1'b0;
    @(posedge clk); #1;   // idx 1
    @(posedge clk); #1;   // idx 2
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_diff", 128'(diff), 128'(0));
    check("midrst_bout", 128'(bout), 128'(0));
    check("midrst_in_ready_low", 128'(in_ready), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    stale = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("midrst_no_stale", 128'(stale), 128'(0));
    run_op(65'd10, 65'd4, 1'b1, 0, rd, rbo, lat, busy_ok, ok);
    check("midrst_after_diff", 128'(rd), 128'(5));
    check("midrst_after_bout", 128'(rbo), 128'(0));

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbi;
      ra = rand65(); rb = rand65(); rbi = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb = ra;
      ref_sub(ra, rb, rbi, md, mbo);
      run_op(ra, rb, rbi, $urandom_range(0, 3), rd, rbo, lat, busy_ok, ok);
      check($sformatf("rand%0d_diff", i), 128'(rd), 128'(md));
      check($sformatf("rand%0d_bout", i), 128'(rbo), 128'(mbo));
      check($sformatf("rand%0d_handshake", i), 128'(ok & busy_ok), 128'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Issue an operation and stop at the first out_valid without consuming it.
  task automatic run_op_start(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_first_valid", 128'(out_valid), 128'(1));
  endtask

endmodule

// File: doc/chunked_subtractor.md
Name: chunked_subtractor

Overview:
- Multi-cycle unsigned subtractor: diff = a - b - bin over WIDTH bits, with borrow-out. It is the inverse of the team's 65-bit combinational adder.
- Computes CHUNK bits per cycle and ripples the borrow between cycles. This keeps the timing path short at large WIDTH.
- Sits behind a valid/ready operand interface and drives a valid/ready result interface. It is fed by the same file-driven vector flow used for the adder.

Parameters:
- WIDTH, 65, operand/result width in bits.
- CHUNK, 16, bits processed per cycle. Legal range 1..WIDTH.
- NCHUNK (localparam), ceil(WIDTH/CHUNK), number of compute cycles. Value is 5 at defaults. The last chunk is WIDTH-(NCHUNK-1)*CHUNK bits wide (1 bit at defaults).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  out  1  borrow-out; 1 iff a < b + bin (unsigned, exact).

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, chunk index=0, internal borrow=0, diff=0, bout=0, out_valid=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
- States: IDLE, CALC, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Both are decoded from registered state.
- IDLE:
  - When in_valid & in_ready in cycle T: latch a, b; borrow<=bin; idx<=0; go to CALC.
  - in_valid without acceptance causes no state change.
- CALC, one chunk per cycle, idx = 0..NCHUNK-1, LSB chunk first:
  - diff[idx chunk] <= a_chunk - b_chunk - borrow.
  - borrow <= borrow-out of that chunk, computed at the chunk's true width; the last chunk borrows from bit WIDTH-1.
  - When idx==NCHUNK-1: bout<=final borrow and go to DONE. Otherwise idx<=idx+1.
  - in_valid is ignored.
- Latency: operands accepted at T give out_valid=1 at T+NCHUNK+1 (T+6 at defaults).
- DONE:
  - diff and bout are held stable while out_ready=0, for unlimited cycles.
  - On out_valid & out_ready: go to IDLE; in_ready=1 next cycle.
  - diff/bout keep their last values until the next computation overwrites them.
- No overlap: at most one operation in flight. Minimum issue interval is NCHUNK+2 cycles.
- Wrap-around: a result below zero wraps mod 2^WIDTH and sets bout=1.
- Edge cases:
  - bin=1 with a==b gives diff all-ones, bout=1.
  - CHUNK==WIDTH gives NCHUNK=1 (latency 2).
  - CHUNK=1 gives bit-serial operation.
- Reset mid-operation (CALC or DONE): abort, return to the reset values above, produce no result.
- a, b, bin are don't-care outside the accepting cycle.

Test Plan (WIDTH=65, CHUNK=16):
- Basic: a=5, b=3, bin=0, accepted at T -> out_valid at T+6; diff=2, bout=0; in_ready=0 during T+1..T+6.
- Underflow wrap: a=0, b=1, bin=0 -> diff=0x1_FFFF_FFFF_FFFF_FFFF, bout=1.
- Cross-chunk borrow ripple: a=0x1_0000_0000_0000_0000, b=0, bin=1 -> diff=0x0_FFFF_FFFF_FFFF_FFFF, bout=0. This exercises the borrow through all 5 chunks, including the 1-bit top chunk.
- Borrow-in only: a=b=0x1_FFFF_FFFF_FFFF_FFFF, bin=1 -> diff=0x1_FFFF_FFFF_FFFF_FFFF, bout=1. Back-to-back repeat with bin=0 -> diff=0, bout=0; the second op is accepted the cycle after the first result handshake.
- Backpressure: result ready, out_ready=0 for 10 cycles while in_valid=1 with new operands. Required: diff/bout unchanged, out_valid=1, in_ready=0, new operands not consumed. Raise out_ready -> next cycle in_ready=1, new operands accepted.
- Reset mid-CALC: assert rst_n=0 for one edge during chunk idx=2 -> next cycle out_valid=0, diff=0, bout=0; after release in_ready=1 and no stale result ever appears. A following a=10, b=4, bin=1 gives diff=5, bout=0.
